control_unit: RTL

Multi-cycle control FSM for the K&S processor. It sits directly upstream of `data_path`, which it drives through every enable/select/operation line. It fetches each instruction, consumes `decoded_instruction` and the registered flags (`zero_op`, `neg_op`) back from the datapath, and sequences load, store, ALU, branch and halt execution. It also owns the RAM write strobe and the processor `halt` status.

---
 rtl/control_unit.sv | 262 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/control_unit.sv
// -----------------------------------------------------------------------------
// k_and_s_pkg / control_unit
//
// Multi-cycle control FSM for the K&S processor. It fetches each instruction,
// waits one cycle for the IR decode to settle, then sequences load, store,
// move, ALU, branch and halt execution by driving every enable/select line of
// data_path. It also owns the RAM write strobe and the processor halt status.
//
// Parameters
//   MEM_LATENCY        cycles from ram_addr stable to data_in valid (>= 1)
//
// Ports
//   clk                 in   system clock, rising edge
//   rst_n               in   asynchronous active-low reset
//   decoded_instruction in   current IR decode from data_path
//   zero_op, neg_op     in   registered flags from data_path
//   unsigned_overflow   in   reserved, unused
//   signed_overflow     in   reserved, unused
//   branch              out  PC load select (1 = operand, 0 = increment)
//   pc_enable           out  PC update strobe
//   ir_enable           out  IR capture strobe
//   addr_sel            out  RAM address source (1 = PC, 0 = operand)
//   c_sel               out  register write source (0 = ALU, 1 = data_in)
//   operation           out  ALU op: 00 OR, 01 ADD, 10 SUB, 11 AND
//   write_reg_enable    out  register bank write strobe
//   flags_reg_enable    out  flag register update strobe
//   ram_write_enable    out  RAM write strobe
//   halt                out  high once HALT executes
//
// Handshake: there is no valid/ready pair here; every output is a
// combinational function of the registered state, the wait counter, the
// current decode and the flags, and is consumed by data_path on the next
// rising edge of clk.
// -----------------------------------------------------------------------------

package k_and_s_pkg;

    typedef enum logic [3:0] {
        I_NOP    = 4'd0,
        I_LOAD   = 4'd1,
        I_STORE  = 4'd2,
        I_MOVE   = 4'd3,
        I_ADD    = 4'd4,
        I_SUB    = 4'd5,
        I_AND    = 4'd6,
        I_OR     = 4'd7,
        I_BRANCH = 4'd8,
        I_BZERO  = 4'd9,
        I_BNZERO = 4'd10,
        I_BNEG   = 4'd11,
        I_BNNEG  = 4'd12,
        I_HALT   = 4'd13
    } decoded_instruction_type;

endpackage

module control_unit
    import k_and_s_pkg::*;
#(
    parameter int MEM_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  decoded_instruction_type decoded_instruction,
    input  logic                    zero_op,
    input  logic                    neg_op,
    input  logic                    unsigned_overflow,
    input  logic                    signed_overflow,
    output logic                    branch,
    output logic                    pc_enable,
    output logic                    ir_enable,
    output logic                    addr_sel,
    output logic                    c_sel,
    output logic [1:0]              operation,
    output logic                    write_reg_enable,
    output logic                    flags_reg_enable,
    output logic                    ram_write_enable,
    output logic                    halt
);

    localparam int WCNT_W = $clog2(MEM_LATENCY + 1);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MEM_LATENCY - 1);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_LOAD   = 3'd2,
        S_STORE  = 3'd3,
        S_MOVE   = 3'd4,
        S_ALU    = 3'd5,
        S_BRANCH = 3'd6,
        S_HALT   = 3'd7
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [WCNT_W-1:0]   wcnt;
    logic [WCNT_W-1:0]   wcnt_next;
    logic                wait_last;
    logic                branch_taken;

    // Overflow flags are reserved for future conditional branches.
    logic unused_overflow;
    assign unused_overflow = unsigned_overflow ^ signed_overflow;

    assign wait_last = (wcnt == WCNT_LAST);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
            wcnt  <= '0;
        end else begin
            state <= state_next;
            wcnt  <= wcnt_next;
        end
    end

    // -------------------------------------------------------------------------
    // Branch condition, evaluated against the flags registered by the most
    // recent ALU instruction.
    // -------------------------------------------------------------------------
    always_comb begin
        branch_taken = 1'b0;
        case (decoded_instruction)
            I_BRANCH: branch_taken = 1'b1;
            I_BZERO:  branch_taken = zero_op;
            I_BNZERO: branch_taken = ~zero_op;
            I_BNEG:   branch_taken = neg_op;
            I_BNNEG:  branch_taken = ~neg_op;
            default:  branch_taken = 1'b0;
        endcase
    end

    // -------------------------------------------------------------------------
    // Next state, wait counter and outputs
    // -------------------------------------------------------------------------
    always_comb begin
        state_next       = state;
        wcnt_next        = '0;
        branch           = 1'b0;
        pc_enable        = 1'b0;
        ir_enable        = 1'b0;
        addr_sel         = 1'b1;
        c_sel            = 1'b0;
        operation        = 2'b00;
        write_reg_enable = 1'b0;
        flags_reg_enable = 1'b0;
        ram_write_enable = 1'b0;
        halt             = 1'b0;

        case (state)
            S_FETCH: begin
                addr_sel = 1'b1;
                if (wait_last) begin
                    ir_enable  = 1'b1;
                    pc_enable  = 1'b1;
                    branch     = 1'b0;
                    state_next = S_DECODE;
                end else begin
                    wcnt_next = wcnt + WCNT_W'(1);
                end
            end

            S_DECODE: begin
                case (decoded_instruction)
                    I_LOAD:   state_next = S_LOAD;
                    I_STORE:  state_next = S_STORE;
                    I_MOVE:   state_next = S_MOVE;
                    I_ADD,
                    I_SUB,
                    I_AND,
                    I_OR:     state_next = S_ALU;
                    I_BRANCH,
                    I_BZERO,
                    I_BNZERO,
                    I_BNEG,
                    I_BNNEG:  state_next = S_BRANCH;
                    I_HALT:   state_next = S_HALT;
                    // NOP and unknown encodings return straight to fetch.
                    default:  state_next = S_FETCH;
                endcase
            end

            S_LOAD: begin
                addr_sel = 1'b0;
                if (wait_last) begin
                    c_sel            = 1'b1;
                    write_reg_enable = 1'b1;
                    state_next       = S_FETCH;
                end else begin
                    wcnt_next = wcnt + WCNT_W'(1);
                end
            end

            S_STORE: begin
                addr_sel         = 1'b0;
                ram_write_enable = 1'b1;
                state_next       = S_FETCH;
            end

            S_MOVE: begin
                // ALU in OR mode passes the source register through; flags
                // are deliberately left untouched.
                c_sel            = 1'b0;
                operation        = 2'b00;
                write_reg_enable = 1'b1;
                state_next       = S_FETCH;
            end

            S_ALU: begin
                c_sel            = 1'b0;
                write_reg_enable = 1'b1;
                flags_reg_enable = 1'b1;
                case (decoded_instruction)
                    I_ADD:   operation = 2'b01;
                    I_SUB:   operation = 2'b10;
                    I_AND:   operation = 2'b11;
                    default: operation = 2'b00;
                endcase
                state_next = S_FETCH;
            end

            S_BRANCH: begin
                if (branch_taken) begin
                    pc_enable = 1'b1;
                    branch    = 1'b1;
                    addr_sel  = 1'b0;
                end
                state_next = S_FETCH;
            end

            S_HALT: begin
                halt       = 1'b1;
                state_next = S_HALT;
            end

            default: begin
                state_next = S_FETCH;
            end
        endcase

        // While reset is held the state register sits in FETCH with wcnt=0,
        // which for MEM_LATENCY=1 would decode as a fetch strobe; force the
        // idle output pattern instead.
        if (!rst_n) begin
            branch           = 1'b0;
            pc_enable        = 1'b0;
            ir_enable        = 1'b0;
            addr_sel         = 1'b1;
            c_sel            = 1'b0;
            operation        = 2'b00;
            write_reg_enable = 1'b0;
            flags_reg_enable = 1'b0;
            ram_write_enable = 1'b0;
            halt             = 1'b0;
        end
    end

endmodule
